// File: rtl/loa_seq_pkg.sv
// Shared types and constants for the sequential lower-part-OR adder.
// The clamp helper bounds the requested approximate byte count to the slice count.
package loa_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPROX = 2'd1,
        ST_ADD    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int WIDTH_DEF = 32;
    localparam int SLICE     = 8;
    localparam int NSLICE    = WIDTH_DEF / SLICE;

    // Requests above nmax saturate to nmax (all bytes approximated).
    function automatic logic [2:0] clamp_k(input logic [7:0] req, input int unsigned nmax);
        if (req > 8'(nmax)) begin
            return 3'(nmax);
        end
        return req[2:0];
    endfunction

endpackage

// File: rtl/loa_seq_add32_ctrl_rca.sv
// 8-bit ripple-carry adder slice; the single shared adder of the sequential LOA.
module rca_8bits (
    output logic [7:0] Sum,
    output logic       Cout,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin
);

    logic [8:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign Sum[i]  = A[i] ^ B[i] ^ c[i];
        assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[8];

endmodule

// File: rtl/loa_seq_add32_ctrl.sv
// Sequential 32-bit lower-part-OR adder: low k bytes approximated by OR in one
// cycle, remaining bytes added exactly one per cycle through a shared 8-bit slice.
module loa_seq_add32_ctrl
    import loa_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [AW-1:0]    approx_slices,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = 3;
    localparam int IW     = $clog2(NSLICE);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [KW-1:0]    k_q, k_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] approx_mask;
    logic             approx_carry;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;

    // OR-mask over the low k bytes, carry from the top approximated bit, and
    // operand byte selection for the shared slice.
    always_comb begin
        approx_mask  = '0;
        approx_carry = 1'b0;
        slice_a      = '0;
        slice_b      = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (i < int'(k_q)) begin
                approx_mask[i*SLICE +: SLICE] = '1;
            end
            if (i == int'(k_q) - 1) begin
                approx_carry = a_q[i*SLICE + SLICE - 1] & b_q[i*SLICE + SLICE - 1];
            end
            if (idx_q == IW'(i)) begin
                slice_a = a_q[i*SLICE +: SLICE];
                slice_b = b_q[i*SLICE +: SLICE];
            end
        end
    end

    rca_8bits u_slice (
        .Sum  (slice_sum),
        .Cout (slice_cout),
        .A    (slice_a),
        .B    (slice_b),
        .Cin  (carry_q)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        k_d     = k_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    k_d     = clamp_k(8'(approx_slices), NSLICE);
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = (k_d != '0) ? ST_APPROX : ST_ADD;
                end
            end
            ST_APPROX: begin
                sum_d   = (a_q | b_q) & approx_mask;
                carry_d = approx_carry;
                if (k_q == KW'(NSLICE)) begin
                    cout_d  = approx_carry;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = IW'(k_q);
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (idx_q == IW'(i)) begin
                        sum_d[i*SLICE +: SLICE] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (idx_q == IW'(NSLICE - 1)) begin
                    cout_d  = slice_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_loa_seq_add32_ctrl.sv
// Self-checking bench for loa_seq_add32_ctrl against an arithmetic LOA model.
module tb_loa_seq_add32_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  approx_slices;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    loa_seq_add32_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .approx_slices (approx_slices),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .sum           (sum),
        .cout          (cout),
        .busy          (busy)
    );

    // Model: low 8k bits = a|b, upper part = exact add of the remaining bits
    // with carry-in from the AND of the top approximated bit pair. Bit 32 is cout.
    function automatic logic [32:0] loa_ref(input logic [31:0] x, input logic [31:0] y, input int k);
        logic [63:0] lo_mask, up, tot;
        int sh;
        logic c;
        sh = k * 8;
        lo_mask = (64'd1 << sh) - 64'd1;
        c = 1'b0;
        if (k > 0) c = x[sh-1] & y[sh-1];
        up  = ({32'b0, x} >> sh) + ({32'b0, y} >> sh) + {63'b0, c};
        tot = ({32'b0, x | y} & lo_mask) | (up << sh);
        return tot[32:0];
    endfunction

    function automatic int clamp4(input int r);
        return (r > 4) ? 4 : r;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; approx_slices = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        chk_cnt++; if ({cout, sum} !== 33'h0) $display("FAIL reset_sum got=%b/%h exp=0/00000000", cout, sum); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Accepts one operand set, waits for the result (bounded), checks latency,
    // sum, cout, then completes the output handshake after 'hold' stalled cycles.
    task automatic run_txn(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic [2:0] req, input int hold);
        logic [32:0] exp;
        int k, lat, exp_lat;
        k = clamp4(int'(req));
        exp = loa_ref(x, y, k);
        exp_lat = ((k > 0) ? 1 : 0) + (4 - k);
        @(negedge clk);
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL %s_ready_before got=%b exp=1", name, in_ready); else pass_cnt++;
        a = x; b = y; approx_slices = req; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; approx_slices = 3'($urandom_range(7, 0));
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk_cnt++; if (lat !== exp_lat) $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); else pass_cnt++;
        chk_cnt++; if (sum !== exp[31:0]) $display("FAIL %s_sum got=%h exp=%h (a=%h b=%h k=%0d)", name, sum, exp[31:0], x, y, k); else pass_cnt++;
        chk_cnt++; if (cout !== exp[32]) $display("FAIL %s_cout got=%b exp=%b", name, cout, exp[32]); else pass_cnt++;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== exp[31:0] || cout !== exp[32])
                $display("FAIL %s_hold%0d got=v%b r%b %b/%h exp=v1 r0 %b/%h", name, i, out_valid, in_ready, cout, sum, exp[32], exp[31:0]);
            else pass_cnt++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s_release got=v%b r%b busy%b exp=v0 r1 busy0", name, out_valid, in_ready, busy);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        run_txn("exact", 32'h000000FF, 32'h00000001, 3'd0, 0);
        run_txn("ripple", 32'hFFFFFFFF, 32'h00000001, 3'd0, 0);
        run_txn("approx1", 32'h000000FF, 32'h00000081, 3'd1, 0);
        run_txn("approx3", 32'h12FF80FF, 32'h01808001, 3'd3, 0);
        run_txn("clamp", 32'h80000001, 32'h80000002, 3'd7, 0);
    endtask

    task automatic test_backpressure();
        logic [32:0] exp;
        exp = loa_ref(32'hDEADBEEF, 32'h01234567, 2);
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h01234567; approx_slices = 3'd2; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0]; a = $urandom; b = $urandom; approx_slices = 3'd0;
            @(posedge clk);
            #1;
            chk_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== exp[31:0] || cout !== exp[32])
                $display("FAIL bp_stall%0d got=v%b r%b %b/%h exp=v1 r0 %b/%h", i, out_valid, in_ready, cout, sum, exp[32], exp[31:0]);
            else pass_cnt++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release got=r%b v%b exp=r1 v0", in_ready, out_valid); else pass_cnt++;
        repeat (6) @(posedge clk);
        #1;
        chk_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL bp_no_capture got=busy%b v%b exp=busy0 v0", busy, out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a = 32'h12345678; b = 32'h11111111; approx_slices = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || sum !== 32'h0 || cout !== 1'b0)
            $display("FAIL midrst got=v%b busy%b r%b %b/%h exp=v0 busy0 r1 0/00000000", out_valid, busy, in_ready, cout, sum);
        else pass_cnt++;
        run_txn("after_rst", 32'h12345678, 32'h11111111, 3'd0, 0);
        chk_cnt++; if (sum !== 32'h23456789) $display("FAIL after_rst_const got=%h exp=23456789", sum); else pass_cnt++;
    endtask

    task automatic test_reset_done();
        @(negedge clk);
        a = 32'hFFFF0000; b = 32'h0001FFFF; approx_slices = 3'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== 32'h0 || cout !== 1'b0)
            $display("FAIL donerst got=v%b busy%b %b/%h exp=v0 busy0 0/00000000", out_valid, busy, cout, sum);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        for (int n = 0; n < 40; n++) begin
            x = $urandom; y = $urandom;
            if (n % 8 == 0) y = ~x;
            if (n % 8 == 1) begin x = 32'hFFFFFFFF; y = $urandom_range(255, 1); end
            run_txn("rand", x, y, 3'($urandom_range(7, 0)), $urandom_range(2, 0));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; approx_slices = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_reset_done();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
